// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into 32-bit
// words, writes them to IMEM one per COMMIT cycle and keeps the core halted until done.
module imem_loader #(
  parameter int IMEM_SIZE = 256,
  parameter int AW        = 8
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          start,
  input  logic          abort,
  input  logic [AW:0]   len,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          WE,
  output logic [31:0]   W_Addr,
  output logic [31:0]   W_Ins,
  output logic          core_halt,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [31:0]   checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT, DONE} state_t;

  localparam logic [AW:0] MAX_LEN = (AW+1)'(IMEM_SIZE);

  state_t      state_q, state_d;
  logic [AW:0] len_q, len_d;
  logic [AW:0] word_cnt_q, word_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_q, word_d;
  logic [31:0] checksum_q, checksum_d;
  logic        err_q, err_d;

  logic        idle_or_done;
  logic        len_ok;
  logic        accept;
  logic [AW:0] word_cnt_inc;

  assign idle_or_done = (state_q == IDLE) || (state_q == DONE);
  assign len_ok       = (len != '0) && (len <= MAX_LEN);
  // abort wins over a byte handshake in the same cycle, so no byte is taken then
  assign accept       = (state_q == LOAD) && !abort && in_valid;
  assign word_cnt_inc = word_cnt_q + (AW+1)'(1);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start && len_ok) state_d = LOAD;
      LOAD: begin
        if (abort)                          state_d = IDLE;
        else if (accept && byte_cnt_q == 2'd3) state_d = COMMIT;
      end
      COMMIT: begin
        if (abort)                     state_d = IDLE;
        else if (word_cnt_inc == len_q) state_d = DONE;
        else                           state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == LOAD) && !abort;
    WE        = (state_q == COMMIT) && !abort;
    // word_cnt_q < len_q <= IMEM_SIZE in COMMIT, so the low AW bits hold the index
    W_Addr    = (state_q == COMMIT) ? {{(30-AW){1'b0}}, word_cnt_q[AW-1:0], 2'b00} : '0;
    W_Ins     = (state_q == COMMIT) ? word_q : '0;
    core_halt = (state_q != DONE);
    busy      = (state_q == LOAD) || (state_q == COMMIT);
    done      = (state_q == DONE);
    err       = err_q;
    checksum  = checksum_q;
  end

  always_comb begin
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    checksum_d = checksum_q;
    err_d      = err_q;
    if (idle_or_done && start) begin
      if (len_ok) begin
        len_d      = len;
        word_cnt_d = '0;
        byte_cnt_d = '0;
        checksum_d = '0;
        err_d      = 1'b0;
      end else begin
        err_d      = 1'b1;
      end
    end else if (state_q == LOAD) begin
      if (abort) begin
        byte_cnt_d = '0;
      end else if (accept) begin
        word_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
        byte_cnt_d = byte_cnt_q + 2'd1;
      end
    end else if (state_q == COMMIT) begin
      byte_cnt_d = '0;
      if (!abort) begin
        checksum_d = checksum_q + word_q;
        word_cnt_d = word_cnt_inc;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      checksum_q <= '0;
      err_q      <= 1'b0;
    end else begin
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      checksum_q <= checksum_d;
      err_q      <= err_d;
    end
  end

endmodule
